// File: rtl/bridge_pkg.sv
// Shared types and constants for the AXI cache bridge: FSM state encodings,
// fixed AXI field values and the latched request record.
package bridge_pkg;

    localparam int REQ_ADDR_W = 32;

    localparam logic       ID_INST    = 1'b0;
    localparam logic       ID_DATA    = 1'b1;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    // The address field is sized by REQ_ADDR_W; the top's ADDR_W must match it.
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
    } req_t;

endpackage

// File: rtl/bridge_wr_ch.sv
// Write channel of the cache bridge: dcache writeback FSM (AW, then W beats, then B)
// with an 8-bit beat counter that raises wlast on the beat matching the latched len.
module bridge_wr_ch
    import bridge_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                dw_valid_i,
    output logic                dw_ready_o,
    input  req_t                dw_req_i,
    input  logic                rd_dcache_busy_i,
    input  logic                dw_wvalid_i,
    output logic                dw_wready_o,
    input  logic [DATA_W-1:0]   dw_wdata_i,
    input  logic [DATA_W/8-1:0] dw_wstrb_i,
    output logic                dw_done_o,
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [7:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,
    output logic [1:0]          awlock_o,
    output logic [3:0]          awcache_o,
    output logic [2:0]          awprot_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ID_W-1:0]     wid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic                idle_o
);

    wr_state_e  wr_q, wr_d;
    req_t       req_q, req_d;
    logic [7:0] beat_q, beat_d;

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through the block leaves a variable unassigned (no latches).
    always_comb begin
        wr_d        = wr_q;
        req_d       = req_q;
        beat_d      = beat_q;
        dw_ready_o  = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        dw_wready_o = 1'b0;
        bready_o    = 1'b0;
        dw_done_o   = 1'b0;
        case (wr_q)
            W_IDLE: begin
                // The reset term keeps dw_ready low while aresetn is asserted.
                if (aresetn && dw_valid_i && !rd_dcache_busy_i) begin
                    dw_ready_o = 1'b1;
                    req_d      = dw_req_i;
                    beat_d     = 8'd0;
                    wr_d       = W_ADDR;
                end
            end
            W_ADDR: begin
                awvalid_o = 1'b1;
                if (awready_i) wr_d = W_DATA;
            end
            W_DATA: begin
                wvalid_o    = dw_wvalid_i;
                dw_wready_o = wready_i;
                if (dw_wvalid_i && wready_i) begin
                    if (beat_q == req_q.len) wr_d = W_RESP;
                    else beat_d = beat_q + 8'd1;
                end
            end
            W_RESP: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    dw_done_o = 1'b1;
                    wr_d      = W_IDLE;
                end
            end
            default: wr_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q   <= W_IDLE;
            req_q  <= '0;
            beat_q <= 8'd0;
        end else begin
            wr_q   <= wr_d;
            req_q  <= req_d;
            beat_q <= beat_d;
        end
    end

    assign awid_o    = ID_W'(ID_DATA);
    assign awaddr_o  = req_q.addr;
    assign awlen_o   = req_q.len;
    assign awsize_o  = req_q.size;
    assign awburst_o = BURST_INCR;
    assign awlock_o  = 2'b00;
    assign awcache_o = 4'b0000;
    assign awprot_o  = 3'b000;

    assign wid_o   = ID_W'(ID_DATA);
    assign wdata_o = dw_wdata_i;
    assign wstrb_o = dw_wstrb_i;
    assign wlast_o = (wr_q == W_DATA) && (beat_q == req_q.len);
    assign idle_o  = (wr_q == W_IDLE);

endmodule

// File: rtl/axi_cache_bridge.sv
// Merges icache refills, dcache refills and dcache writebacks onto one AXI master port.
// Optional statistic counters are built when BRIDGE_STAT_EN is defined.
module axi_cache_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                ir_valid,
    output logic                ir_ready,
    input  logic [ADDR_W-1:0]   ir_addr,
    input  logic [7:0]          ir_len,
    input  logic [2:0]          ir_size,
    output logic                ir_rvalid,
    output logic                ir_rlast,
    output logic                ir_rerr,
    input  logic                dr_valid,
    output logic                dr_ready,
    input  logic [ADDR_W-1:0]   dr_addr,
    input  logic [7:0]          dr_len,
    input  logic [2:0]          dr_size,
    output logic                dr_rvalid,
    output logic                dr_rlast,
    output logic                dr_rerr,
    output logic [DATA_W-1:0]   rdata_o,
    input  logic                dw_valid,
    output logic                dw_ready,
    input  logic [ADDR_W-1:0]   dw_addr,
    input  logic [7:0]          dw_len,
    input  logic [2:0]          dw_size,
    input  logic                dw_wvalid,
    output logic                dw_wready,
    input  logic [DATA_W-1:0]   dw_wdata,
    input  logic [DATA_W/8-1:0] dw_wstrb,
    output logic                dw_done,
    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [31:0]         stat_rd_stall,
    output logic [31:0]         stat_wr_busy
);

    rd_state_e rd_q, rd_d;
    req_t      rd_req_q, rd_req_d;
    logic      rd_owner_q, rd_owner_d;
    logic      ir_grant, dr_grant;
    logic      wr_idle, rd_dcache_busy, rd_beat;
    logic      unused_resp;

    // Dcache reads yield to a pending or active writeback to keep RAW order.
    always_comb begin
        rd_d       = rd_q;
        rd_req_d   = rd_req_q;
        rd_owner_d = rd_owner_q;
        ir_grant   = 1'b0;
        dr_grant   = 1'b0;
        case (rd_q)
            R_IDLE: begin
                if (aresetn && dr_valid && wr_idle && !dw_valid) begin
                    dr_grant   = 1'b1;
                    rd_req_d   = '{addr: dr_addr, len: dr_len, size: dr_size};
                    rd_owner_d = ID_DATA;
                    rd_d       = R_ADDR;
                end else if (aresetn && ir_valid) begin
                    ir_grant   = 1'b1;
                    rd_req_d   = '{addr: ir_addr, len: ir_len, size: ir_size};
                    rd_owner_d = ID_INST;
                    rd_d       = R_ADDR;
                end
            end
            R_ADDR:  if (arready) rd_d = R_DATA;
            R_DATA:  if (rvalid && rlast) rd_d = R_IDLE;
            default: rd_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q       <= R_IDLE;
            rd_req_q   <= '0;
            rd_owner_q <= ID_INST;
        end else begin
            rd_q       <= rd_d;
            rd_req_q   <= rd_req_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ir_ready = ir_grant;
    assign dr_ready = dr_grant;

    assign arid    = ID_W'(rd_owner_q);
    assign araddr  = rd_req_q.addr;
    assign arlen   = rd_req_q.len;
    assign arsize  = rd_req_q.size;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (rd_q == R_ADDR);
    assign rready  = (rd_q == R_DATA);

    // Beats go to the latched owner regardless of rid: only one read is ever in flight.
    assign rd_beat   = rvalid && (rd_q == R_DATA);
    assign ir_rvalid = rd_beat && (rd_owner_q == ID_INST);
    assign dr_rvalid = rd_beat && (rd_owner_q == ID_DATA);
    assign ir_rlast  = ir_rvalid && rlast;
    assign dr_rlast  = dr_rvalid && rlast;
    assign ir_rerr   = ir_rvalid && (rresp != 2'b00);
    assign dr_rerr   = dr_rvalid && (rresp != 2'b00);
    assign rdata_o   = rdata;

    assign rd_dcache_busy = (rd_q != R_IDLE) && (rd_owner_q == ID_DATA);
    assign unused_resp    = ^{rid, bid, bresp};

    bridge_wr_ch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_wr_ch (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .dw_valid_i       (dw_valid),
        .dw_ready_o       (dw_ready),
        .dw_req_i         ('{addr: dw_addr, len: dw_len, size: dw_size}),
        .rd_dcache_busy_i (rd_dcache_busy),
        .dw_wvalid_i      (dw_wvalid),
        .dw_wready_o      (dw_wready),
        .dw_wdata_i       (dw_wdata),
        .dw_wstrb_i       (dw_wstrb),
        .dw_done_o        (dw_done),
        .awid_o           (awid),
        .awaddr_o         (awaddr),
        .awlen_o          (awlen),
        .awsize_o         (awsize),
        .awburst_o        (awburst),
        .awlock_o         (awlock),
        .awcache_o        (awcache),
        .awprot_o         (awprot),
        .awvalid_o        (awvalid),
        .awready_i        (awready),
        .wid_o            (wid),
        .wdata_o          (wdata),
        .wstrb_o          (wstrb),
        .wlast_o          (wlast),
        .wvalid_o         (wvalid),
        .wready_i         (wready),
        .bvalid_i         (bvalid),
        .bready_o         (bready),
        .idle_o           (wr_idle)
    );

`ifdef BRIDGE_STAT_EN
    logic [31:0] stall_cnt_q, busy_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt_q <= 32'd0;
            busy_cnt_q  <= 32'd0;
        end else begin
            if ((ir_valid || dr_valid) && !(ir_grant || dr_grant))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!wr_idle)
                busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign stat_rd_stall = stall_cnt_q;
    assign stat_wr_busy  = busy_cnt_q;
`else
    assign stat_rd_stall = 32'd0;
    assign stat_wr_busy  = 32'd0;
`endif

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge: the bench plays the AXI slave, queues the
// expected read beats and compares them as the bridge forwards them to the caches.
module tb_axi_cache_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

`ifdef BRIDGE_STAT_EN
    localparam logic [31:0] EXP_STALL = 32'd9;
    localparam logic [31:0] EXP_BUSY  = 32'd3;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_BUSY  = 32'd0;
`endif

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                ir_valid, ir_ready, ir_rvalid, ir_rlast, ir_rerr;
    logic [ADDR_W-1:0]   ir_addr;
    logic [7:0]          ir_len;
    logic [2:0]          ir_size;
    logic                dr_valid, dr_ready, dr_rvalid, dr_rlast, dr_rerr;
    logic [ADDR_W-1:0]   dr_addr;
    logic [7:0]          dr_len;
    logic [2:0]          dr_size;
    logic [DATA_W-1:0]   rdata_o;
    logic                dw_valid, dw_ready, dw_wvalid, dw_wready, dw_done;
    logic [ADDR_W-1:0]   dw_addr;
    logic [7:0]          dw_len;
    logic [2:0]          dw_size;
    logic [DATA_W-1:0]   dw_wdata;
    logic [DATA_W/8-1:0] dw_wstrb;
    logic [ID_W-1:0]     arid, rid, awid, wid, bid;
    logic [ADDR_W-1:0]   araddr, awaddr;
    logic [7:0]          arlen, awlen;
    logic [2:0]          arsize, awsize, arprot, awprot;
    logic [1:0]          arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]          arcache, awcache;
    logic                arvalid, arready, rlast, rvalid, rready;
    logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]   rdata, wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [31:0]         stat_rd_stall, stat_wr_busy;

    always #5 aclk = ~aclk;

    axi_cache_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_addr(ir_addr), .ir_len(ir_len),
        .ir_size(ir_size), .ir_rvalid(ir_rvalid), .ir_rlast(ir_rlast), .ir_rerr(ir_rerr),
        .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_addr(dr_addr), .dr_len(dr_len),
        .dr_size(dr_size), .dr_rvalid(dr_rvalid), .dr_rlast(dr_rlast), .dr_rerr(dr_rerr),
        .rdata_o(rdata_o),
        .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_len(dw_len),
        .dw_size(dw_size), .dw_wvalid(dw_wvalid), .dw_wready(dw_wready),
        .dw_wdata(dw_wdata), .dw_wstrb(dw_wstrb), .dw_done(dw_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .stat_rd_stall(stat_rd_stall), .stat_wr_busy(stat_wr_busy)
    );

    typedef struct packed {
        logic        dcache;
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic pop_beat();
        beat_t e;
        e = sb.pop_front();
        check("ir_rvalid", ir_rvalid, !e.dcache);
        check("dr_rvalid", dr_rvalid, e.dcache);
        check("rdata_o", rdata_o, e.data);
        check("ir_rlast", ir_rlast, !e.dcache && e.last);
        check("dr_rlast", dr_rlast, e.dcache && e.last);
        check("ir_rerr", ir_rerr, !e.dcache && e.err);
        check("dr_rerr", dr_rerr, e.dcache && e.err);
    endtask

    // Plays the AR/R slave for a granted read; entered just after the grant edge.
    task automatic serve_read(input logic dcache, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input int ar_delay, input logic [1:0] resp,
                              input logic [3:0] rid_drv);
        int    t;
        beat_t e;
        t = 0;
        arready = 1'b0;
        @(negedge aclk);
        while (arvalid !== 1'b1 && t < 20) begin
            @(negedge aclk);
            t++;
        end
        check("arvalid", arvalid, 1'b1);
        check("arid", arid, {3'b000, dcache});
        check("araddr", araddr, addr);
        check("arlen", arlen, len);
        check("arsize", arsize, size);
        check("arburst", arburst, 2'b01);
        check("ar_lock_cache_prot", {arlock, arcache, arprot}, 9'd0);
        check("rready_in_addr", rready, 1'b0);
        repeat (ar_delay) begin
            @(negedge aclk);
            check("arvalid_hold", arvalid, 1'b1);
            check("araddr_hold", araddr, addr);
        end
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            e.dcache = dcache;
            e.data   = {8'hC0, 7'd0, dcache, 16'(b)};
            e.last   = (b == int'(len));
            e.err    = (resp != 2'b00);
            sb.push_back(e);
            rvalid = 1'b1;
            rdata  = e.data;
            rlast  = e.last;
            rresp  = resp;
            rid    = rid_drv;
            @(negedge aclk);
            check("rready", rready, 1'b1);
            pop_beat();
            cyc();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ir_valid = 0; ir_addr = '0; ir_len = '0; ir_size = '0;
        dr_valid = 0; dr_addr = '0; dr_len = '0; dr_size = '0;
        dw_valid = 0; dw_addr = '0; dw_len = '0; dw_size = '0;
        dw_wvalid = 0; dw_wdata = '0; dw_wstrb = '0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_rready_bready", {rready, bready}, 2'b00);
        check("rst_readies", {ir_ready, dr_ready, dw_ready, dw_wready}, 4'b0000);
        check("rst_pulses", {dw_done, ir_rvalid, dr_rvalid}, 3'b000);
        check("rst_stat_rd_stall", stat_rd_stall, 32'd0);
        check("rst_stat_wr_busy", stat_wr_busy, 32'd0);
        cyc();
        aresetn = 1'b1;
        cyc();

        // 1: icache 8-beat refill
        ir_valid = 1; ir_addr = 32'hBFC0_0000; ir_len = 8'd7; ir_size = 3'd2;
        @(negedge aclk);
        check("t1_ir_ready", ir_ready, 1'b1);
        check("t1_dr_ready", dr_ready, 1'b0);
        cyc();
        ir_valid = 0;
        serve_read(1'b0, 32'hBFC0_0000, 8'd7, 3'd2, 0, 2'b00, 4'd0);

        // 2: simultaneous requests, dcache first, icache right after its rlast
        ir_valid = 1; ir_addr = 32'h0000_1000; ir_len = 8'd1; ir_size = 3'd2;
        dr_valid = 1; dr_addr = 32'h8000_0040; dr_len = 8'd3; dr_size = 3'd2;
        @(negedge aclk);
        check("t2_dr_ready", dr_ready, 1'b1);
        check("t2_ir_ready", ir_ready, 1'b0);
        cyc();
        dr_valid = 0;
        serve_read(1'b1, 32'h8000_0040, 8'd3, 3'd2, 0, 2'b00, 4'd1);
        @(negedge aclk);
        check("t2_ir_after_rlast", ir_ready, 1'b1);
        cyc();
        ir_valid = 0;
        serve_read(1'b0, 32'h0000_1000, 8'd1, 3'd2, 0, 2'b00, 4'd0);

        // 3: writeback wins over a pending dcache read
        dw_valid = 1; dw_addr = 32'h8000_1000; dw_len = 8'd3; dw_size = 3'd2;
        dr_valid = 1; dr_addr = 32'h8000_1000; dr_len = 8'd0; dr_size = 3'd2;
        @(negedge aclk);
        check("t3_dw_ready", dw_ready, 1'b1);
        check("t3_dr_blocked", dr_ready, 1'b0);
        cyc();
        dw_valid = 0; dw_wvalid = 1; dw_wdata = 32'h5A00_0000; dw_wstrb = 4'hF;
        @(negedge aclk);
        check("t3_awvalid", awvalid, 1'b1);
        check("t3_awid_wid", {awid, wid}, 8'h11);
        check("t3_awaddr", awaddr, 32'h8000_1000);
        check("t3_awlen_size_burst", {awlen, awsize, awburst}, {8'd3, 3'd2, 2'b01});
        check("t3_no_w_before_aw", wvalid, 1'b0);
        check("t3_dr_wait_aw", dr_ready, 1'b0);
        cyc();
        awready = 1;
        cyc();
        awready = 0; wready = 1;
        for (int b = 0; b < 4; b++) begin
            dw_wdata = 32'h5A00_0000 + 32'(b);
            dw_wstrb = (b == 1) ? 4'h3 : 4'hF;
            @(negedge aclk);
            check("t3_wvalid", wvalid, 1'b1);
            check("t3_dw_wready", dw_wready, 1'b1);
            check("t3_wdata", wdata, 32'h5A00_0000 + 32'(b));
            check("t3_wstrb", wstrb, (b == 1) ? 4'h3 : 4'hF);
            check("t3_wlast", wlast, b == 3);
            cyc();
        end
        dw_wvalid = 0; wready = 0;
        repeat (4) begin
            @(negedge aclk);
            check("t3_bready", bready, 1'b1);
            check("t3_no_done_yet", dw_done, 1'b0);
            check("t3_dr_wait_b", dr_ready, 1'b0);
            cyc();
        end
        bvalid = 1;
        @(negedge aclk);
        check("t3_dw_done", dw_done, 1'b1);
        cyc();
        bvalid = 0;
        @(negedge aclk);
        check("t3_done_pulse_end", dw_done, 1'b0);
        check("t3_dr_granted", dr_ready, 1'b1);
        cyc();
        dr_valid = 0;
        serve_read(1'b1, 32'h8000_1000, 8'd0, 3'd2, 0, 2'b00, 4'd1);

        // 4: single-beat dcache read, SLVERR, mismatched rid still routed to dcache
        dr_valid = 1; dr_addr = 32'h8000_2000; dr_len = 8'd0; dr_size = 3'd2;
        @(negedge aclk);
        check("t4_dr_ready", dr_ready, 1'b1);
        cyc();
        dr_valid = 0;
        serve_read(1'b1, 32'h8000_2000, 8'd0, 3'd2, 1, 2'b10, 4'd3);

        // 5: async reset mid read burst and mid write burst
        ir_valid = 1; ir_addr = 32'h0000_2000; ir_len = 8'd3; ir_size = 3'd2;
        dw_valid = 1; dw_addr = 32'h0000_3000; dw_len = 8'd3; dw_size = 3'd2;
        @(negedge aclk);
        check("t5_ir_dw_ready", {ir_ready, dw_ready}, 2'b11);
        cyc();
        ir_valid = 0; dw_valid = 0; arready = 1; awready = 1;
        cyc();
        arready = 0; awready = 0;
        sb.push_back('{dcache: 1'b0, data: 32'hC0DE_0000, last: 1'b0, err: 1'b0});
        rvalid = 1; rdata = 32'hC0DE_0000; rlast = 0; rresp = 2'b00; rid = 4'd0;
        dw_wvalid = 1; wready = 1; dw_wdata = 32'h7700_0000; dw_wstrb = 4'hF;
        @(negedge aclk);
        pop_beat();
        check("t5_wvalid_pre", wvalid, 1'b1);
        #2;
        aresetn = 0;
        #1;
        check("t5_rd_valids", {arvalid, rready, ir_rvalid, dr_rvalid}, 4'b0000);
        check("t5_wr_valids", {awvalid, wvalid, wlast, bready}, 4'b0000);
        check("t5_pulses", {dw_done, dw_wready}, 2'b00);
        rvalid = 0; dw_wvalid = 0; wready = 0;
        repeat (2) cyc();
        aresetn = 1;
        cyc();
        @(negedge aclk);
        check("t5_write_dropped", {awvalid, wvalid, bready}, 3'b000);
        cyc();
        ir_valid = 1; ir_addr = 32'h0000_2000; ir_len = 8'd1; ir_size = 3'd2;
        @(negedge aclk);
        check("t5_ir_ready_fresh", ir_ready, 1'b1);
        cyc();
        ir_valid = 0;
        serve_read(1'b0, 32'h0000_2000, 8'd1, 3'd2, 0, 2'b00, 4'd0);

        // 6: ir_valid held 10 cycles with arready withheld; only non-grant cycles count
        ir_valid = 1; ir_addr = 32'h0000_4000; ir_len = 8'd0; ir_size = 3'd2;
        @(negedge aclk);
        check("t6_ir_ready", ir_ready, 1'b1);
        repeat (9) begin
            cyc();
            @(negedge aclk);
            check("t6_no_regrant", ir_ready, 1'b0);
        end
        cyc();
        ir_valid = 0;
        serve_read(1'b0, 32'h0000_4000, 8'd0, 3'd2, 0, 2'b00, 4'd0);
        check("t6_stat_rd_stall", stat_rd_stall, EXP_STALL);

        // Short write: three cycles away from W_IDLE
        dw_valid = 1; dw_addr = 32'h0000_5000; dw_len = 8'd0; dw_size = 3'd2;
        @(negedge aclk);
        check("t6_dw_ready", dw_ready, 1'b1);
        cyc();
        dw_valid = 0; awready = 1;
        cyc();
        awready = 0; dw_wvalid = 1; wready = 1; dw_wdata = 32'h1234_5678; dw_wstrb = 4'hF;
        @(negedge aclk);
        check("t6_wlast_len0", wlast, 1'b1);
        cyc();
        dw_wvalid = 0; wready = 0; bvalid = 1;
        @(negedge aclk);
        check("t6_dw_done", dw_done, 1'b1);
        cyc();
        bvalid = 0;
        @(negedge aclk);
        check("t6_stat_wr_busy", stat_wr_busy, EXP_BUSY);
        check("t6_stat_rd_stall_stable", stat_rd_stall, EXP_STALL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
